sine_dds_src: RTL and testbench
===============================

# sine_dds_src

Direct-digital-synthesis sine source that generates the 18-bit signed test stimulus driven into the symmetric sine-input FIR filter (its `x_in`). A phase accumulator advances once per sample tick, and a quarter-wave lookup table with quadrant folding converts phase to amplitude. A 3-stage pipeline delivers each sample with a one-cycle valid strobe. Output frequency and amplitude are run-time programmable.

## Interface
- `PHASE_W`, 24: phase accumulator width; wraps modulo 2^PHASE_W.
- `LUT_AW`, 8: quarter-wave table address width (2^LUT_AW entries).
- `SAMPLE_DIV`, 4: clock cycles per output sample, ≥1.

- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `freq_word` in PHASE_W: phase increment per sample (unsigned).
- `freq_load` in 1: capture `freq_word` into the pending register this cycle.
- `run` in 1: enables sample ticks.
- `amp_shift` in 2: output attenuation, arithmetic right shift by 0..3.
- `y_out` out 18: signed sample, feeds the filter `x_in`; holds between updates.
- `y_valid` out 1: one-cycle strobe marking a new `y_out`.

## Operation
- **Tick divider**
  - The counter is cleared to 0 and held while `run`=0.
  - While `run`=1, the counter increments 0..SAMPLE_DIV-1 and wraps.
  - A tick occurs when `run`=1 and counter==SAMPLE_DIV-1, so the first tick falls on the SAMPLE_DIV-th cycle of `run` high.
  - With SAMPLE_DIV=1, a tick occurs every `run` cycle.
- **Frequency load**
  - `freq_load`=1 writes `pending` ← `freq_word` and sets `pend_flag`.
  - Multiple loads between ticks: the last one wins.
- **Phase at a tick**
  - Stage 0 captures the current `acc`.
  - `inc` = `pending` if `pend_flag`, else `active`.
  - `acc` ← `acc` + `inc` (mod 2^PHASE_W).
  - If `pend_flag` was set: `active` ← `pending` and `pend_flag` clears.
  - A `freq_load` in the same cycle as a tick does not affect that tick. It sets `pending`/`pend_flag` for the next tick.
- **Phase decode** (from captured phase p)
  - Quadrant q = p[PHASE_W-1:PHASE_W-2].
  - Index k = p[PHASE_W-3 -: LUT_AW].
  - Address = k for q∈{0,2}; address = ~k for q∈{1,3}.
- **Table**
  - Entry i = round(131071·sin(π/2·(i+0.5)/2^LUT_AW)), unsigned 17-bit, ≤131071.
  - LUT_AW=8 gives entry 0 = 402 and entry 255 = 131070.
- **Sign and scale**
  - Magnitude m is positive for q∈{0,1} and negated to 18-bit for q∈{2,3}; negation cannot overflow.
  - The result is then arithmetically shifted right by `amp_shift`, which floors toward −∞.
- **`run` falling**: no new ticks. `acc` and `active` hold, and in-flight samples still emerge. When `run` returns, the phase continues from the held `acc`.
- **Output frequency**: f_out = f_clk·`freq_word`/(SAMPLE_DIV·2^PHASE_W).

## Timing
- **Reset values** (on the edge where `reset`=1): `acc`=0, `active`=0, `pending`=0, `pend_flag`=0, counter=0, all pipeline valids=0, `y_out`=0, `y_valid`=0.
  - In-flight samples are discarded.
  - Reset overrides `run`, `freq_load` and any tick in the same cycle.
- **Pipeline**, for a tick in cycle t:
  - Edge ending t: stage 0 (phase capture, accumulate).
  - Edge ending t+1: stage 1 (registered LUT read plus quadrant bit).
  - Edge ending t+2: stage 2 (sign and shift into `y_out`).
  - `y_valid`=1 during cycle t+3 only.
  - Latency is 3 cycles; throughput is one sample per SAMPLE_DIV cycles.
- **`amp_shift`** is sampled at stage 2, so changes take effect on the next emitted sample.
- **`y_valid`** is never high for two consecutive cycles when SAMPLE_DIV>1. When SAMPLE_DIV=1 it is continuous while `run` stays high.

## Test plan
- **Reset**: `reset` held 2 cycles with `run`=1 and `freq_load`=1 → `y_out`=0 and `y_valid`=0 throughout. After release, the first `y_valid` appears SAMPLE_DIV+3 cycles after the first `run`-high cycle.
- **Quarter-cycle sweep**: PHASE_W=24; `freq_word`=2^22 loaded before `run` → samples 402, 131070, −402, −131070, repeating. `y_valid` spacing is exactly 4 cycles.
- **Attenuation**: same stimulus with `amp_shift`=2 → 100, 32767, −101, −32768.
- **Frequency-load collision**: active 2^22; new word 2^23 loaded in the same cycle as a tick → that tick still advances by 2^22, and following ticks advance by 2^23. Two loads (2^21 then 2^20) between ticks → 2^20 is applied.
- **Run gating**: deassert `run` one cycle after a tick → that sample still emerges 3 cycles after the tick, then no more `y_valid`. Reassert `run` → the next sample continues from the held phase with no repeated or skipped value.
- **Mid-pipeline reset**: `reset` one cycle after a tick → no `y_valid` for that sample, `y_out`=0, and `acc` restarts at 0 (first sample is 402 with `freq_word` 2^22 reloaded).

Source files
------------

// File: rtl/sine_dds_src.sv
// Sine DDS stimulus source: phase accumulator, quarter-wave LUT with
// quadrant folding, 3-stage pipeline to an 18-bit signed sample.
module sine_dds_src #(
  parameter int PHASE_W    = 24,
  parameter int LUT_AW     = 8,
  parameter int SAMPLE_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
  input  logic               run,
  input  logic [1:0]         amp_shift,
  output logic [17:0]        y_out,
  output logic               y_valid
);

  localparam int N  = 1 << LUT_AW;
  localparam int TW = LUT_AW + 2;
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  // Odd Taylor series; argument never exceeds pi/2 so 13 terms is exact
  // to well below one LSB of the 17-bit table.
  function automatic real sin_q(input real x);
    real t;
    real s;
    t = x;
    s = x;
    for (int n = 1; n < 14; n++) begin
      t = -t * x * x / real'((2 * n) * (2 * n + 1));
      s = s + t;
    end
    return s;
  endfunction

  function automatic logic [N*17-1:0] gen_lut();
    logic [N*17-1:0] r;
    int              e;
    real             a;
    r = '0;
    for (int i = 0; i < N; i++) begin
      a = 1.5707963267948966 * (real'(i) + 0.5) / real'(N);
      e = $rtoi(131071.0 * sin_q(a) + 0.5);
      if (e > 131071) e = 131071;
      r[i*17 +: 17] = e[16:0];
    end
    return r;
  endfunction

  localparam logic [N*17-1:0] LUT = gen_lut();

  logic [CW-1:0]      cnt;
  logic               tick;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] active;
  logic [PHASE_W-1:0] pending;
  logic               pend_flag;
  logic [PHASE_W-1:0] inc;

  logic [TW-1:0]      ph0;
  logic               v0;
  logic [LUT_AW-1:0]  k;
  logic [LUT_AW-1:0]  addr;

  logic [16:0]        mag1;
  logic               neg1;
  logic               v1;
  logic signed [17:0] s2;

  assign tick = run & (cnt == CNT_LAST);
  assign inc  = pend_flag ? pending : active;

  assign k    = ph0[LUT_AW-1:0];
  assign addr = ph0[TW-2] ? ~k : k;

  always_comb begin
    s2 = $signed({1'b0, mag1});
    if (neg1) s2 = -$signed({1'b0, mag1});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      active    <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
      ph0       <= '0;
      v0        <= 1'b0;
      mag1      <= '0;
      neg1      <= 1'b0;
      v1        <= 1'b0;
      y_out     <= '0;
      y_valid   <= 1'b0;
    end else begin
      if (!run || cnt == CNT_LAST) cnt <= '0;
      else                         cnt <= cnt + 1'b1;

      if (tick) begin
        ph0 <= acc[PHASE_W-1 -: TW];
        acc <= acc + inc;
        if (pend_flag) active <= pending;
      end

      // A load in a tick cycle lands after the tick has consumed pending.
      if (freq_load) begin
        pending   <= freq_word;
        pend_flag <= 1'b1;
      end else if (tick) begin
        pend_flag <= 1'b0;
      end

      v0 <= tick;

      if (v0) begin
        mag1 <= LUT[int'(addr) * 17 +: 17];
        neg1 <= ph0[TW-1];
      end
      v1 <= v0;

      if (v1) y_out <= s2 >>> amp_shift;
      y_valid <= v1;
    end
  end

endmodule

// File: tb/tb_sine_dds_src.sv
// Randomized + directed bench for sine_dds_src against a
// sample-level reference built from $sin.
module tb_sine_dds_src;

  localparam int PW  = 24;
  localparam int LA  = 8;
  localparam int DIV = 4;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] freq_word;
  logic          freq_load;
  logic          run;
  logic [1:0]    amp_shift;
  logic [17:0]   y_out;
  logic          y_valid;

  int tests = 0;
  int fails = 0;

  sine_dds_src #(
    .PHASE_W(PW), .LUT_AW(LA), .SAMPLE_DIV(DIV)
  ) dut (
    .clk(clk), .reset(reset), .freq_word(freq_word),
    .freq_load(freq_load), .run(run), .amp_shift(amp_shift),
    .y_out(y_out), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  // Sample for a phase: sine evaluated at the centre of its
  // 1/(4*2^LA)-of-a-cycle bin, magnitude rounded to nearest.
  function automatic logic signed [17:0] ref_sample(input logic [PW-1:0] p);
    int  n;
    real s;
    real a;
    int  mag;
    n   = int'(p >> (PW - LA - 2));
    s   = $sin(2.0 * PI * (real'(n) + 0.5) / real'(4 << LA));
    a   = (s < 0.0) ? -s : s;
    mag = $rtoi(131071.0 * a + 0.5);
    if (s < 0.0) return 18'(-mag);
    return 18'(mag);
  endfunction

  typedef struct {
    int                 e2;
    logic signed [17:0] v;
  } ent_t;

  ent_t               mq[$];
  logic [PW-1:0]      m_acc, m_act, m_pend;
  bit                 m_pf;
  int                 m_cnt;
  int                 ecount = 0;
  bit                 armed = 0;
  logic signed [17:0] ey;
  bit                 ev;
  bit                 m_tick;

  always @(posedge clk) begin
    ecount++;
    if (reset) begin
      m_acc = '0; m_act = '0; m_pend = '0; m_pf = 0; m_cnt = 0;
      mq.delete();
      ey = '0; ev = 0;
    end else begin
      ev = 0;
      if (mq.size() > 0 && mq[0].e2 == ecount) begin
        ey = mq[0].v >>> amp_shift;
        ev = 1;
        void'(mq.pop_front());
      end
      m_tick = run && (m_cnt == DIV - 1);
      m_cnt  = (!run || m_cnt == DIV - 1) ? 0 : m_cnt + 1;
      if (m_tick) begin
        mq.push_back('{ecount + 2, ref_sample(m_acc)});
        m_acc = m_acc + (m_pf ? m_pend : m_act);
        if (m_pf) begin m_act = m_pend; m_pf = 0; end
      end
      if (freq_load) begin m_pend = freq_word; m_pf = 1; end
    end
    armed = 1;
  end

  bit pv = 0;
  always @(negedge clk) begin
    if (armed) begin
      tests++;
      if (y_valid !== ev) begin
        fails++;
        $display("FAIL y_valid t=%0t got %b want %b", $time, y_valid, ev);
      end
      tests++;
      if (y_out !== ey) begin
        fails++;
        $display("FAIL y_out t=%0t got %0d want %0d", $time,
                 $signed(y_out), ey);
      end
      if (y_valid) begin
        tests++;
        if (pv) begin
          fails++;
          $display("FAIL strobe_width t=%0t got back-to-back want single", $time);
        end
      end
      pv = y_valid;
    end
  end

  int sv[$];
  int st[$];
  always @(negedge clk) begin
    if (armed && y_valid) begin
      sv.push_back(int'($signed(y_out)));
      st.push_back(ecount);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int getv(input int i);
    return (i < sv.size()) ? sv[i] : 999999;
  endfunction

  task automatic wait_n(input int n, input int lim);
    int c = 0;
    while (sv.size() < n && c < lim) begin
      @(negedge clk); #1; c++;
    end
    if (sv.size() < n) begin
      tests++; fails++;
      $display("FAIL timeout got %0d samples want %0d", sv.size(), n);
    end
  endtask

  task automatic restart(input logic [PW-1:0] fw, input logic [1:0] amp);
    reset = 1; run = 0; freq_load = 0;
    repeat (2) @(negedge clk);
    reset = 0; freq_word = fw; freq_load = 1; amp_shift = amp;
    @(negedge clk);
    freq_load = 0;
    sv.delete(); st.delete();
    run = 1;
  endtask

  int first;
  int nv;
  int lq[$];

  initial begin
    reset = 1; run = 1; freq_load = 1;
    freq_word = 24'h400000; amp_shift = 0;

    chk("model_0", int'(ref_sample(24'h000000)), 402);
    chk("model_q1", int'(ref_sample(24'h3fffff)), 131070);
    chk("model_q3", int'(ref_sample(24'hffffff)), -402);

    repeat (2) begin
      @(negedge clk);
      chk("rst_y", int'(y_out), 0);
      chk("rst_v", int'(y_valid), 0);
    end
    reset = 0; run = 0; freq_load = 1;
    @(negedge clk);
    freq_load = 0;
    @(negedge clk);
    sv.delete(); st.delete();
    run = 1; first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (y_valid && first == 0) first = k + 1;
    end
    chk("first_latency", first, DIV + 3);
    wait_n(8, 60);
    lq = '{402, 131070, -402, -131070};
    for (int i = 0; i < 8; i++) chk("sweep", getv(i), lq[i % 4]);
    for (int i = 0; i < 7 && i + 1 < st.size(); i++)
      chk("spacing", st[i+1] - st[i], DIV);

    restart(24'h400000, 2'd2);
    wait_n(4, 40);
    lq = '{100, 32767, -101, -32768};
    for (int i = 0; i < 4; i++) chk("atten", getv(i), lq[i]);

    restart(24'h400000, 2'd0);
    repeat (7) @(negedge clk);
    freq_word = 24'h800000; freq_load = 1;
    @(negedge clk);
    freq_load = 0;
    repeat (12) @(negedge clk);
    freq_word = 24'h200000; freq_load = 1;
    @(negedge clk);
    freq_load = 0;
    @(negedge clk);
    freq_word = 24'h100000; freq_load = 1;
    @(negedge clk);
    freq_load = 0;
    wait_n(8, 60);
    lq = '{402, 131070, -402, 402, -402, 402};
    for (int i = 0; i < 6; i++) chk("collide", getv(i), lq[i]);
    chk("two_loads_a", getv(6), int'(ref_sample(24'h100000)));
    chk("two_loads_b", getv(7), int'(ref_sample(24'h200000)));

    restart(24'h400000, 2'd0);
    repeat (8) @(negedge clk);
    run = 0;
    repeat (2) @(negedge clk);
    #1 chk("gate_inflight", int'(y_valid), 1);
    nv = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (y_valid) nv++;
    end
    chk("gate_quiet", nv, 0);
    chk("gate_count", sv.size(), 2);
    run = 1;
    wait_n(4, 40);
    chk("gate_resume0", getv(2), -402);
    chk("gate_resume1", getv(3), -131070);

    restart(24'h400000, 2'd0);
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0; freq_word = 24'h400000; freq_load = 1;
    @(negedge clk);
    freq_load = 0;
    #1;
    chk("midrst_v", int'(y_valid), 0);
    chk("midrst_y", int'(y_out), 0);
    repeat (2) @(negedge clk);
    #1 chk("midrst_drop", sv.size(), 0);
    wait_n(2, 40);
    chk("midrst_first", getv(0), 402);
    chk("midrst_second", getv(1), 131070);

    restart(24'h400000, 2'd0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 599) == 0);
      run       = ($urandom_range(0, 24) != 0) ? run : ~run;
      freq_load = ($urandom_range(0, 11) == 0);
      freq_word = ($urandom_range(0, 1) == 0) ? 24'($urandom)
                                              : 24'($urandom_range(0, 4095) << 10);
      if ($urandom_range(0, 29) == 0) amp_shift = 2'($urandom_range(0, 3));
    end
    run = 0; freq_load = 0; reset = 0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
